// File: rtl/mem_reinit_ctrl.sv
// Write-port arbiter for a block-RAM wrapper: user writes in IDLE, or a sequential
// re-initialisation fill of DEPTH_MEM words streamed in address order.
module mem_reinit_ctrl #(
    parameter int WID_MEM   = 1,
    parameter int EXP_MEM   = 16,
    parameter int DEPTH_MEM = 2**16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               usr_wr_valid,
    output logic               usr_wr_ready,
    input  logic [EXP_MEM-1:0] usr_waddr,
    input  logic [WID_MEM-1:0] usr_wdata,
    input  logic               usr_rd_valid,
    input  logic [EXP_MEM-1:0] usr_raddr,
    output logic               usr_rdata_valid,
    output logic [WID_MEM-1:0] usr_rdata,
    input  logic               reinit_start,
    input  logic               reinit_abort,
    input  logic               fill_valid,
    output logic               fill_ready,
    input  logic [WID_MEM-1:0] fill_data,
    output logic               busy,
    output logic               done,
    output logic [EXP_MEM:0]   fill_count,
    output logic               mem_we,
    output logic [EXP_MEM-1:0] mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic [EXP_MEM-1:0] mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [EXP_MEM-1:0] LAST_PTR = EXP_MEM'(DEPTH_MEM - 1);

    state_t             state_q;
    logic [EXP_MEM-1:0] ptr_q;
    logic [EXP_MEM:0]   fill_count_q;
    logic               usr_wr_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               rdata_valid_q;

    logic usr_acc;
    logic beat_acc;

    // Abort wins over a beat offered in the same cycle, so it also gates ready.
    assign fill_ready = (state_q == FILL) && !reinit_abort;
    assign beat_acc   = fill_ready && fill_valid;
    assign usr_acc    = usr_wr_valid && usr_wr_ready_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_din   = '0;
        if (beat_acc) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_din   = fill_data;
        end else if (usr_acc) begin
            mem_we    = 1'b1;
            mem_waddr = usr_waddr;
            mem_din   = usr_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            fill_count_q   <= '0;
            usr_wr_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reinit_start) begin
                        state_q        <= FILL;
                        ptr_q          <= '0;
                        fill_count_q   <= '0;
                        usr_wr_ready_q <= 1'b0;
                        busy_q         <= 1'b1;
                    end else begin
                        usr_wr_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (reinit_abort) begin
                        state_q        <= IDLE;
                        busy_q         <= 1'b0;
                        usr_wr_ready_q <= 1'b1;
                    end else if (beat_acc) begin
                        fill_count_q <= fill_count_q + 1'b1;
                        // ptr holds on the last beat so it never wraps.
                        if (ptr_q == LAST_PTR) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q        <= IDLE;
                    usr_wr_ready_q <= 1'b1;
                end
                default: begin
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    usr_wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= usr_rd_valid;
        end
    end

    assign usr_wr_ready    = usr_wr_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign fill_count      = fill_count_q;
    assign mem_raddr       = usr_raddr;
    assign usr_rdata       = mem_dout;
    assign usr_rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Directed bench for mem_reinit_ctrl with a 16x8 block-RAM model (registered read, read-before-write).
module tb_mem_reinit_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       usr_wr_valid, usr_wr_ready;
    logic [3:0] usr_waddr;
    logic [7:0] usr_wdata;
    logic       usr_rd_valid, usr_rdata_valid;
    logic [3:0] usr_raddr;
    logic [7:0] usr_rdata;
    logic       reinit_start, reinit_abort;
    logic       fill_valid, fill_ready;
    logic [7:0] fill_data;
    logic       busy, done;
    logic [4:0] fill_count;
    logic       mem_we;
    logic [3:0] mem_waddr, mem_raddr;
    logic [7:0] mem_din, mem_dout;

    logic [7:0] ram [0:15];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_din;
        mem_dout <= ram[mem_raddr];
    end

    mem_reinit_ctrl #(.WID_MEM(8), .EXP_MEM(4), .DEPTH_MEM(16)) dut (
        .clk(clk), .reset(reset),
        .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready),
        .usr_waddr(usr_waddr), .usr_wdata(usr_wdata),
        .usr_rd_valid(usr_rd_valid), .usr_raddr(usr_raddr),
        .usr_rdata_valid(usr_rdata_valid), .usr_rdata(usr_rdata),
        .reinit_start(reinit_start), .reinit_abort(reinit_abort),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
        .busy(busy), .done(done), .fill_count(fill_count),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        usr_wr_valid = 1'b1; usr_waddr = a; usr_wdata = d;
        #1;
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_waddr), 32'(a));
        chk("wr_din", 32'(mem_din), 32'(d));
        tick();
        usr_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        usr_rd_valid = 1'b1; usr_raddr = a;
        tick();
        usr_rd_valid = 1'b0;
        chk("rd_valid", 32'(usr_rdata_valid), 1);
        chk($sformatf("rd_data@%0d", a), 32'(usr_rdata), 32'(exp));
    endtask

    // Beats first..first+n-1 with data base^index; optional gap every 3rd cycle.
    task automatic beats(input int first, input int n, input logic [7:0] base, input bit gaps);
        int b = first;
        int cyc = 0;
        while (b < first + n && cyc < 200) begin
            if (gaps && (cyc % 3 == 2)) begin
                fill_valid = 1'b0;
                #1;
                chk("gap_we", 32'(mem_we), 0);
            end else begin
                fill_valid = 1'b1;
                fill_data  = base ^ 8'(b);
                #1;
                chk("beat_we", 32'(mem_we), 1);
                chk("beat_addr", 32'(mem_waddr), 32'(b & 15));
                chk("beat_din", 32'(mem_din), 32'(base ^ 8'(b)));
                b++;
            end
            chk("fill_done_low", 32'(done), 0);
            chk("fill_ready_low", 32'(usr_wr_ready), 0);
            tick();
            cyc++;
        end
        fill_valid = 1'b0;
        chk("beats_completed", 32'(b), 32'(first + n));
    endtask

    task automatic start_fill();
        reinit_start = 1'b1;
        tick();
        reinit_start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_cnt", 32'(fill_count), 0);
        chk("start_fready", 32'(fill_ready), 1);
    endtask

    task automatic check_done();
        #1;
        chk("done_pulse", 32'(done), 1);
        chk("done_cnt", 32'(fill_count), 16);
        chk("done_busy", 32'(busy), 0);
        chk("done_rdy", 32'(usr_wr_ready), 0);
        chk("done_fready", 32'(fill_ready), 0);
        tick();
        chk("post_done", 32'(done), 0);
        chk("post_rdy", 32'(usr_wr_ready), 1);
    endtask

    initial begin
        reset = 1'b0;
        usr_wr_valid = 1'b0; usr_waddr = '0; usr_wdata = '0;
        usr_rd_valid = 1'b0; usr_raddr = '0;
        reinit_start = 1'b0; reinit_abort = 1'b0;
        fill_valid = 1'b0; fill_data = '0;
        #2;
        chk("rst_rdy", 32'(usr_wr_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(fill_count), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_rvalid", 32'(usr_rdata_valid), 0);
        tick();
        reset = 1'b1;
        chk("rdy_before_edge", 32'(usr_wr_ready), 0);
        tick();
        chk("rdy_after_edge", 32'(usr_wr_ready), 1);

        // 1: write / read, plus same-address read during write returns old data
        wr(4'd3, 8'hA5);
        usr_raddr = 4'd3;
        #1;
        chk("raddr_pass", 32'(mem_raddr), 3);
        rd(4'd3, 8'hA5);
        usr_wr_valid = 1'b1; usr_waddr = 4'd3; usr_wdata = 8'h77;
        usr_rd_valid = 1'b1; usr_raddr = 4'd3;
        tick();
        usr_wr_valid = 1'b0; usr_rd_valid = 1'b0;
        chk("rw_same_old", 32'(usr_rdata), 32'hA5);
        rd(4'd3, 8'h77);

        // 2: full fill with gaps
        start_fill();
        beats(0, 16, 8'hFF, 1'b1);
        check_done();
        for (int a = 0; a < 16; a++) rd(4'(a), 8'(a) ^ 8'hFF);

        // 3: user write held through FILL and DONE
        start_fill();
        usr_wr_valid = 1'b1; usr_waddr = 4'd2; usr_wdata = 8'h11;
        beats(0, 16, 8'h40, 1'b0);
        #1;
        chk("done_no_usr_we", 32'(mem_we), 0);
        check_done();
        chk("idle_usr_we", 32'(mem_we), 1);
        chk("idle_usr_addr", 32'(mem_waddr), 2);
        tick();
        usr_wr_valid = 1'b0;
        rd(4'd2, 8'h11);
        rd(4'd3, 8'h43);

        // 4: prefill zeros, abort after 5 beats
        for (int a = 0; a < 16; a++) wr(4'(a), 8'h00);
        start_fill();
        beats(0, 5, 8'hE0, 1'b0);
        reinit_abort = 1'b1; fill_valid = 1'b1; fill_data = 8'hEE;
        #1;
        chk("abort_fready", 32'(fill_ready), 0);
        chk("abort_we", 32'(mem_we), 0);
        tick();
        reinit_abort = 1'b0; fill_valid = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_cnt", 32'(fill_count), 5);
        chk("abort_rdy", 32'(usr_wr_ready), 1);
        tick();
        chk("abort_done_later", 32'(done), 0);
        for (int a = 0; a < 16; a++) rd(4'(a), (a < 5) ? (8'hE0 ^ 8'(a)) : 8'h00);

        // 5: asynchronous reset mid-fill, then a complete fill
        start_fill();
        beats(0, 7, 8'h80, 1'b0);
        fill_valid = 1'b1; fill_data = 8'h87;
        #1;
        chk("pre_rst_we", 32'(mem_we), 1);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_cnt", 32'(fill_count), 0);
        chk("arst_we", 32'(mem_we), 0);
        tick();
        reset = 1'b1; fill_valid = 1'b0;
        tick();
        start_fill();
        beats(0, 16, 8'h80, 1'b0);
        check_done();
        rd(4'd0, 8'h80);
        rd(4'd7, 8'h87);
        rd(4'd15, 8'h8F);

        // 6: start with same-cycle user write; restart during FILL is ignored
        usr_wr_valid = 1'b1; usr_waddr = 4'd9; usr_wdata = 8'h3C;
        reinit_start = 1'b1;
        #1;
        chk("start_wr_we", 32'(mem_we), 1);
        chk("start_wr_addr", 32'(mem_waddr), 9);
        chk("start_wr_din", 32'(mem_din), 32'h3C);
        tick();
        usr_wr_valid = 1'b0; reinit_start = 1'b0;
        chk("s6_busy", 32'(busy), 1);
        chk("s6_rdy", 32'(usr_wr_ready), 0);
        rd(4'd9, 8'h3C);
        beats(0, 3, 8'h50, 1'b0);
        reinit_start = 1'b1;
        beats(3, 1, 8'h50, 1'b0);
        reinit_start = 1'b0;
        chk("restart_cnt", 32'(fill_count), 4);
        chk("restart_busy", 32'(busy), 1);
        beats(4, 12, 8'h50, 1'b0);
        check_done();
        rd(4'd9, 8'h59);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
